// File: rtl/msx_ram_arbiter.sv
// N-channel request/ack arbiter onto the shared MSX SDRAM/BRAM port; one access in flight.
// Define MSX_ARB_ROUND_ROBIN_EN for round-robin grants; default is fixed priority (ch0 highest).
module msx_ram_arbiter #(
  parameter int CHANNELS  = 4,
  parameter int ADDR_W    = 27,
  parameter int DATA_W    = 8,
  parameter int SDRAM_LAT = 3,
  parameter int BRAM_LAT  = 1
) (
  input  logic                       clk21m,
  input  logic                       reset,
  input  logic [CHANNELS-1:0]        ch_req,
  input  logic [CHANNELS*ADDR_W-1:0] ch_addr,
  input  logic [CHANNELS*DATA_W-1:0] ch_din,
  input  logic [CHANNELS-1:0]        ch_rnw,
  input  logic [CHANNELS-1:0]        ch_bram,
  output logic [CHANNELS-1:0]        ch_ack,
  output logic [DATA_W-1:0]          ch_rdata,
  output logic [CHANNELS-1:0]        ch_rvalid,
  output logic [ADDR_W-1:0]          ram_addr,
  output logic [DATA_W-1:0]          ram_din,
  output logic                       ram_rnw,
  output logic                       sdram_ce,
  output logic                       bram_ce,
  input  logic [DATA_W-1:0]          ram_dout
);
  localparam int GW      = $clog2(CHANNELS);
  localparam int MAX_LAT = (SDRAM_LAT > BRAM_LAT) ? SDRAM_LAT : BRAM_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                             state;
  logic [CHANNELS-1:0][ADDR_W-1:0]    addr_v;
  logic [CHANNELS-1:0][DATA_W-1:0]    din_v;
  logic [GW-1:0]                      gnt;
  logic [GW-1:0]                      pick;
  logic                               pick_vld;
  logic                               bram_sel;
  logic [CW-1:0]                      cnt;
  logic [CW-1:0]                      lat_m1;
  logic [DATA_W-1:0]                  rdata_q;

  assign addr_v = ch_addr;
  assign din_v  = ch_din;
  assign lat_m1 = bram_sel ? CW'(BRAM_LAT - 1) : CW'(SDRAM_LAT - 1);

  // Read data is forwarded straight from memory in the ack cycle, then held.
  assign ch_rdata = (|ch_rvalid) ? ram_dout : rdata_q;

`ifdef MSX_ARB_ROUND_ROBIN_EN
  logic [GW-1:0] last;

  always_comb begin
    int j;
    logic [GW-1:0] idx;
    pick_vld = 1'b0;
    pick     = '0;
    j        = 0;
    idx      = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      j   = (int'(last) + 1 + k) % CHANNELS;
      idx = GW'(j);
      if (!pick_vld && ch_req[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  always_ff @(posedge clk21m) begin
    if (reset) last <= GW'(CHANNELS - 1);
    else if (state == IDLE && pick_vld) last <= pick;
  end
`else
  always_comb begin
    logic [GW-1:0] idx;
    pick_vld = 1'b0;
    pick     = '0;
    idx      = '0;
    // Scan high to low so the lowest requesting index is the last writer.
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      idx = GW'(k);
      if (ch_req[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end
`endif

  always_ff @(posedge clk21m) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      bram_sel  <= 1'b0;
      cnt       <= '0;
      ram_addr  <= '0;
      ram_din   <= '0;
      ram_rnw   <= 1'b1;
      sdram_ce  <= 1'b0;
      bram_ce   <= 1'b0;
      ch_ack    <= '0;
      ch_rvalid <= '0;
      rdata_q   <= '0;
    end else begin
      sdram_ce  <= 1'b0;
      bram_ce   <= 1'b0;
      ch_ack    <= '0;
      ch_rvalid <= '0;
      if (|ch_rvalid) rdata_q <= ram_dout;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt      <= pick;
            ram_addr <= addr_v[pick];
            ram_din  <= din_v[pick];
            ram_rnw  <= ch_rnw[pick];
            bram_sel <= ch_bram[pick];
            sdram_ce <= ~ch_bram[pick];
            bram_ce  <= ch_bram[pick];
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= lat_m1;
          state <= WAIT;
          // Ack is registered one cycle early so it lands on the zero-count cycle.
          if (lat_m1 == '0) begin
            ch_ack[gnt]    <= 1'b1;
            ch_rvalid[gnt] <= ram_rnw;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
              ch_ack[gnt]    <= 1'b1;
              ch_rvalid[gnt] <= ram_rnw;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_msx_ram_arbiter.sv
// Bench for msx_ram_arbiter: directed scenarios plus a randomized run against a timestamp model.
`timescale 1ns/1ps
module tb_msx_ram_arbiter;
  localparam int CH = 4, AW = 27, DW = 8, SL = 3, BL = 1;

  logic              clk21m = 1'b0;
  logic              reset;
  logic [CH-1:0]     ch_req, ch_rnw, ch_bram, ch_ack, ch_rvalid;
  logic [CH*AW-1:0]  ch_addr;
  logic [CH*DW-1:0]  ch_din;
  logic [DW-1:0]     ch_rdata, ram_din, ram_dout;
  logic [AW-1:0]     ram_addr;
  logic              ram_rnw, sdram_ce, bram_ce;
  int                checks = 0, failures = 0;
  logic [DW-1:0]     rd_hold;

  always #5 clk21m = ~clk21m;

  msx_ram_arbiter #(.CHANNELS(CH), .ADDR_W(AW), .DATA_W(DW), .SDRAM_LAT(SL), .BRAM_LAT(BL)) dut (
    .clk21m(clk21m), .reset(reset), .ch_req(ch_req), .ch_addr(ch_addr), .ch_din(ch_din),
    .ch_rnw(ch_rnw), .ch_bram(ch_bram), .ch_ack(ch_ack), .ch_rdata(ch_rdata),
    .ch_rvalid(ch_rvalid), .ram_addr(ram_addr), .ram_din(ram_din), .ram_rnw(ram_rnw),
    .sdram_ce(sdram_ce), .bram_ce(bram_ce), .ram_dout(ram_dout));

  function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  // Memory: data valid only in the cycle issue+LAT, noise otherwise.
  int            lat_left = 0;
  logic [AW-1:0] mem_a = '0;
  always @(posedge clk21m) begin
    if (sdram_ce || bram_ce) begin
      lat_left = sdram_ce ? SL : BL;
      mem_a    = ram_addr;
    end else if (lat_left > 0) lat_left--;
    #2 ram_dout = (lat_left == 1) ? memval(mem_a) : DW'($urandom);
  end

  task automatic tick();
    @(posedge clk21m); #1;
  endtask

  task automatic set_ch(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic rnw, input logic br);
    ch_addr[i*AW +: AW] = a;
    ch_din[i*DW +: DW]  = d;
    ch_rnw[i]           = rnw;
    ch_bram[i]          = br;
  endtask

  task automatic do_reset();
    reset = 1'b1; ch_req = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ch_req = '0;
    tick(); tick();
    @(negedge clk21m);
    checks++; if (ram_addr !== '0) begin failures++; $display("FAIL reset_addr: got %h want 0", ram_addr); end
    checks++; if (ram_din !== '0) begin failures++; $display("FAIL reset_din: got %h want 0", ram_din); end
    checks++; if (ram_rnw !== 1'b1) begin failures++; $display("FAIL reset_rnw: got %b want 1", ram_rnw); end
    checks++; if ({sdram_ce, bram_ce} !== 2'b00) begin failures++; $display("FAIL reset_ce: got %b want 00", {sdram_ce, bram_ce}); end
    checks++; if (ch_ack !== '0 || ch_rvalid !== '0) begin failures++; $display("FAIL reset_ack: got %b/%b want 0/0", ch_ack, ch_rvalid); end
    checks++; if (ch_rdata !== '0) begin failures++; $display("FAIL reset_rdata: got %h want 0", ch_rdata); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_sdram_read();
    logic [AW-1:0] a;
    logic [CH-1:0] ea;
    a = 27'h0001234;
    set_ch(1, a, 8'h00, 1'b1, 1'b0);
    ch_req[1] = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk21m);
      ea = (k == 4) ? 4'b0010 : 4'b0000;
      checks++; if (sdram_ce !== (k == 1)) begin failures++; $display("FAIL rd_sdram_ce c%0d: got %b want %b", k, sdram_ce, k == 1); end
      checks++; if (bram_ce !== 1'b0) begin failures++; $display("FAIL rd_bram_ce c%0d: got %b want 0", k, bram_ce); end
      checks++; if (ch_ack !== ea) begin failures++; $display("FAIL rd_ack c%0d: got %b want %b", k, ch_ack, ea); end
      checks++; if (ch_rvalid !== ea) begin failures++; $display("FAIL rd_rvalid c%0d: got %b want %b", k, ch_rvalid, ea); end
      if (k >= 1 && k <= 4) begin
        checks++; if (ram_addr !== a || ram_rnw !== 1'b1) begin failures++; $display("FAIL rd_addr c%0d: got %h/%b want %h/1", k, ram_addr, ram_rnw, a); end
      end
      if (k == 4) begin
        checks++; if (ch_rdata !== memval(a)) begin failures++; $display("FAIL rd_data: got %h want %h", ch_rdata, memval(a)); end
      end
      tick();
      if (k == 4) ch_req[1] = 1'b0;
    end
    rd_hold = memval(a);
  endtask

  task automatic test_bram_write();
    logic [CH-1:0] ea;
    set_ch(2, 27'h0000777, 8'h3C, 1'b0, 1'b1);
    ch_req[2] = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk21m);
      ea = (k == 2) ? 4'b0100 : 4'b0000;
      checks++; if (bram_ce !== (k == 1)) begin failures++; $display("FAIL wr_bram_ce c%0d: got %b want %b", k, bram_ce, k == 1); end
      checks++; if (sdram_ce !== 1'b0) begin failures++; $display("FAIL wr_sdram_ce c%0d: got %b want 0", k, sdram_ce); end
      checks++; if (ch_ack !== ea) begin failures++; $display("FAIL wr_ack c%0d: got %b want %b", k, ch_ack, ea); end
      checks++; if (ch_rvalid !== '0) begin failures++; $display("FAIL wr_rvalid c%0d: got %b want 0", k, ch_rvalid); end
      checks++; if (ch_rdata !== rd_hold) begin failures++; $display("FAIL wr_rdata c%0d: got %h want %h", k, ch_rdata, rd_hold); end
      if (k == 1) begin
        checks++; if (ram_rnw !== 1'b0 || ram_din !== 8'h3C) begin failures++; $display("FAIL wr_bus: got %b/%h want 0/3c", ram_rnw, ram_din); end
      end
      tick();
      if (k == 2) ch_req[2] = 1'b0;
    end
  endtask

  task automatic test_withdraw();
    logic [CH-1:0] ea;
    set_ch(1, 27'h0ABCDEF, 8'h11, 1'b1, 1'b0);
    set_ch(2, 27'h0000100, 8'h22, 1'b1, 1'b1);
    ch_req[1] = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk21m);
      ea = (k == 4) ? 4'b0010 : 4'b0000;
      checks++; if (ch_ack !== ea) begin failures++; $display("FAIL wd_ack c%0d: got %b want %b", k, ch_ack, ea); end
      checks++; if (sdram_ce !== (k == 1) || bram_ce !== 1'b0) begin failures++; $display("FAIL wd_ce c%0d: got %b%b want %b0", k, sdram_ce, bram_ce, k == 1); end
      tick();
      if (k == 0) ch_req[2] = 1'b1;
      if (k == 1) ch_req[1] = 1'b0;
      if (k == 2) ch_req[2] = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] a1, a3;
    logic [CH-1:0] ea;
    a1 = AW'($urandom);
    a3 = AW'($urandom);
    set_ch(1, a1, 8'h00, 1'b1, 1'b0);
    set_ch(3, a3, 8'h00, 1'b1, 1'b0);
    ch_req[1] = 1'b1;
    for (int k = 0; k <= 14; k++) begin
      @(negedge clk21m);
      if (k == 2) begin
        checks++; if (ram_addr !== a1) begin failures++; $display("FAIL rm_hold: got %h want %h", ram_addr, a1); end
      end
      if (k == 3) begin
        checks++; if (ram_rnw !== 1'b1 || ram_addr !== '0) begin failures++; $display("FAIL rm_bus: got %b/%h want 1/0", ram_rnw, ram_addr); end
      end
      if (k >= 3) begin
        ea = (k == 11) ? 4'b1000 : 4'b0000;
        checks++; if (ch_ack !== ea || ch_rvalid !== ea) begin failures++; $display("FAIL rm_ack c%0d: got %b/%b want %b", k, ch_ack, ch_rvalid, ea); end
        checks++; if (sdram_ce !== (k == 8) || bram_ce !== 1'b0) begin failures++; $display("FAIL rm_ce c%0d: got %b%b want %b0", k, sdram_ce, bram_ce, k == 8); end
      end
      if (k == 11) begin
        checks++; if (ch_rdata !== memval(a3)) begin failures++; $display("FAIL rm_data: got %h want %h", ch_rdata, memval(a3)); end
      end
      tick();
      if (k == 1) reset = 1'b1;
      if (k == 2) begin reset = 1'b0; ch_req[1] = 1'b0; end
      if (k == 6) ch_req[3] = 1'b1;
      if (k == 11) ch_req[3] = 1'b0;
    end
  endtask

  task automatic test_fairness();
    int got[$];
    int c, last_c, idx, expv;
    do_reset();
    for (int i = 0; i < CH; i++) set_ch(i, AW'($urandom), DW'($urandom), 1'b1, 1'b0);
    ch_req = '1;
    c = 0; last_c = -1;
    while (got.size() < 5 && c < 200) begin
      @(negedge clk21m);
      if (ch_ack != '0) begin
        checks++; if (!$onehot(ch_ack)) begin failures++; $display("FAIL fair_onehot: got %b want one-hot", ch_ack); end
        idx = 0;
        for (int i = 0; i < CH; i++) if (ch_ack[i]) idx = i;
        got.push_back(idx);
        if (last_c >= 0) begin
          checks++; if (c - last_c != SL + 2) begin failures++; $display("FAIL fair_gap: got %0d want %0d", c - last_c, SL + 2); end
        end
        last_c = c;
      end
      tick();
      c++;
    end
    checks++; if (got.size() != 5) begin failures++; $display("FAIL fair_timeout: got %0d acks want 5", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
`ifdef MSX_ARB_ROUND_ROBIN_EN
      expv = i % CH;
`else
      expv = 0;
`endif
      checks++; if (got[i] != expv) begin failures++; $display("FAIL fair_order[%0d]: got %0d want %0d", i, got[i], expv); end
    end
    ch_req = '0;
    repeat (10) tick();
  endtask

  task automatic test_random();
    logic          busy, m_rnw, m_bram;
    int            m_g, m_issue, m_ack, rr_last;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din, last_rd, exp_rd;
    logic [CH-1:0] ack_seen, exp_ack, exp_rv;
    do_reset();
    busy = 1'b0; m_rnw = 1'b1; m_bram = 1'b0; m_g = 0; m_issue = 0; m_ack = 0;
    m_addr = '0; m_din = '0; last_rd = '0; rr_last = CH - 1; ack_seen = '0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < CH; i++) begin
        if (ack_seen[i]) ch_req[i] = 1'b0;
        else if (ch_req[i] && $urandom_range(0, 19) == 0) ch_req[i] = 1'b0;
        else if (!ch_req[i] && $urandom_range(0, 3) == 0) begin
          set_ch(i, AW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          ch_req[i] = 1'b1;
        end
      end
      @(negedge clk21m);
      exp_ack = (busy && c == m_ack) ? CH'(1) << m_g : '0;
      exp_rv  = m_rnw ? exp_ack : '0;
      exp_rd  = (exp_rv != '0) ? memval(m_addr) : last_rd;
      checks++; if (sdram_ce !== (busy && c == m_issue && !m_bram)) begin failures++; $display("FAIL rnd_sdram_ce c%0d: got %b", c, sdram_ce); end
      checks++; if (bram_ce !== (busy && c == m_issue && m_bram)) begin failures++; $display("FAIL rnd_bram_ce c%0d: got %b", c, bram_ce); end
      checks++; if (ch_ack !== exp_ack) begin failures++; $display("FAIL rnd_ack c%0d: got %b want %b", c, ch_ack, exp_ack); end
      checks++; if (ch_rvalid !== exp_rv) begin failures++; $display("FAIL rnd_rvalid c%0d: got %b want %b", c, ch_rvalid, exp_rv); end
      checks++; if (ch_rdata !== exp_rd) begin failures++; $display("FAIL rnd_rdata c%0d: got %h want %h", c, ch_rdata, exp_rd); end
      if (busy && c >= m_issue) begin
        checks++; if (ram_addr !== m_addr || ram_rnw !== m_rnw || ram_din !== m_din) begin
          failures++; $display("FAIL rnd_bus c%0d: got %h/%b/%h want %h/%b/%h", c, ram_addr, ram_rnw, ram_din, m_addr, m_rnw, m_din);
        end
      end
      ack_seen = ch_ack;
      if (busy && c == m_ack) begin
        busy = 1'b0;
        if (m_rnw) last_rd = memval(m_addr);
      end else if (!busy && ch_req != '0) begin
        m_g = -1;
`ifdef MSX_ARB_ROUND_ROBIN_EN
        for (int k = 0; k < CH; k++)
          if (m_g < 0 && ch_req[(rr_last + 1 + k) % CH]) m_g = (rr_last + 1 + k) % CH;
        rr_last = m_g;
`else
        for (int k = 0; k < CH; k++) if (m_g < 0 && ch_req[k]) m_g = k;
`endif
        busy    = 1'b1;
        m_addr  = ch_addr[m_g*AW +: AW];
        m_din   = ch_din[m_g*DW +: DW];
        m_rnw   = ch_rnw[m_g];
        m_bram  = ch_bram[m_g];
        m_issue = c + 1;
        m_ack   = c + 1 + (m_bram ? BL : SL);
      end
      tick();
    end
    ch_req = '0;
    repeat (10) tick();
  endtask

  initial begin
    reset = 1'b1; ch_req = '0; ch_addr = '0; ch_din = '0; ch_rnw = '0; ch_bram = '0; rd_hold = '0;
    @(posedge clk21m); #1;
    test_reset();
    test_sdram_read();
    test_bram_write();
    test_withdraw();
    test_reset_mid();
    test_fairness();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
